// File: rtl/timer_countdown_set_pkg.sv
// ---------------------------------------------------------------------------
// timer_pkg
// Shared types and constants for the countdown timer-setter.
//   state_t      : countdown engine states
//   INC..LEFT    : bit positions of the key pulses inside NUM_SYNC
//   SEC_MAX/MIN_MAX : largest legal seconds / minutes value
//   CURSOR_LAST  : index of the right-most editable digit (hour tens)
// ---------------------------------------------------------------------------
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    localparam int INC   = 0;
    localparam int DEC   = 1;
    localparam int RIGHT = 2;
    localparam int LEFT  = 3;

    localparam logic [6:0] SEC_MAX     = 7'd59;
    localparam logic [6:0] MIN_MAX     = 7'd59;
    localparam logic [2:0] CURSOR_LAST = 3'd5;

endpackage

// File: rtl/timer_countdown_set_tick_prescaler.sv
// ---------------------------------------------------------------------------
// tick_prescaler
// Divides CLK down to a one-cycle TICK every TICK_DIV enabled cycles.
//   CLK   in  system clock
//   RESET in  asynchronous, active-low reset
//   EN    in  count enable (held count while low)
//   CLR   in  synchronous clear, wins over EN
//   TICK  out high on the enabled cycle where the count is TICK_DIV-1
// ---------------------------------------------------------------------------
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 1000
) (
    input  logic CLK,
    input  logic RESET,
    input  logic EN,
    input  logic CLR,
    output logic TICK
);

    localparam int unsigned    CW   = $clog2(TICK_DIV);
    localparam logic [CW-1:0]  LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_count;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of block evaluation order.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_count <= '0;
        end else if (CLR) begin
            r_count <= '0;
        end else if (EN) begin
            r_count <= (r_count == LAST) ? '0 : r_count + 1'b1;
        end
    end

    assign TICK = EN && (r_count == LAST);

endmodule

// File: rtl/timer_countdown_set.sv
// ---------------------------------------------------------------------------
// timer_countdown_set
// HH:MM:SS countdown timer with cursor-driven digit editing.
//   CLK      in   system clock
//   RESET    in   asynchronous, active-low reset
//   MODE     in   global mode; editing/cursor active only when == SET_MODE
//   NUM_SYNC in   key pulses [0] inc, [1] dec, [2] cursor right, [3] cursor left
//   START    in   start / pause / resume / acknowledge pulse
//   CURSOR   out  edited digit 0..5 = sec1, sec10, min1, min10, hr1, hr10
//   HOUR     out  0..HOUR_MAX
//   MIN/SEC  out  0..59
//   RUNNING  out  high while counting down
//   ALARM    out  held high once the countdown reached zero
//   DONE     out  one-cycle pulse when the countdown reaches zero
// ---------------------------------------------------------------------------
module timer_countdown_set
    import timer_pkg::*;
#(
    parameter int unsigned HOUR_MAX = 23,
    parameter int unsigned TICK_DIV = 1000,
    parameter logic [3:0]  SET_MODE = 4'b0000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] MODE,
    input  logic [3:0] NUM_SYNC,
    input  logic       START,
    output logic [2:0] CURSOR,
    output logic [6:0] HOUR,
    output logic [6:0] MIN,
    output logic [6:0] SEC,
    output logic       RUNNING,
    output logic       ALARM,
    output logic       DONE
);

    localparam logic [6:0] HOUR_LIMIT = 7'(HOUR_MAX);

    // Edit one decimal digit of a binary field while keeping it in 0..max_val.
    function automatic logic [6:0] edit_field(input logic [6:0] value,
                                              input logic [6:0] max_val,
                                              input logic       is_tens,
                                              input logic       up);
        logic [6:0] t;
        logic [6:0] o;
        logic [6:0] room;
        t    = value / 7'd10;
        o    = value % 7'd10;
        room = 7'd0;
        if (!is_tens) begin
            if (up) begin
                o = (o == 7'd9 || value == max_val) ? 7'd0 : o + 7'd1;
            end else if (o != 7'd0) begin
                o = o - 7'd1;
            end else begin
                // Wrap to the largest ones digit the current tens digit allows.
                room = max_val - 7'd10 * t;
                o    = (room > 7'd9) ? 7'd9 : room;
            end
        end else begin
            if (up) begin
                t = (7'd10 * (t + 7'd1) + o > max_val) ? 7'd0 : t + 7'd1;
            end else if (t != 7'd0) begin
                t = t - 7'd1;
            end else if (o <= max_val) begin
                t = (max_val - o) / 7'd10;
            end else begin
                // No tens digit fits with this ones digit: drop the ones digit.
                o = 7'd0;
                t = max_val / 7'd10;
            end
        end
        return 7'd10 * t + o;
    endfunction

    state_t     r_state, w_next_state;
    logic [2:0] r_cursor, w_next_cursor;
    logic [6:0] r_hour, r_min, r_sec;
    logic [6:0] w_next_hour, w_next_min, w_next_sec;
    logic       r_running, r_alarm, r_done;
    logic       w_tick, w_set_mode, w_edit_en;
    logic       w_inc, w_dec, w_right, w_left;
    logic       w_time_zero, w_next_zero, w_enter_run;

    assign w_set_mode  = (MODE == SET_MODE);
    assign w_edit_en   = w_set_mode && (r_state == IDLE || r_state == PAUSE);
    // Opposing keys pressed together cancel out.
    assign w_inc       = NUM_SYNC[INC]   && !NUM_SYNC[DEC];
    assign w_dec       = NUM_SYNC[DEC]   && !NUM_SYNC[INC];
    assign w_right     = NUM_SYNC[RIGHT] && !NUM_SYNC[LEFT];
    assign w_left      = NUM_SYNC[LEFT]  && !NUM_SYNC[RIGHT];
    assign w_time_zero = (r_hour == 7'd0) && (r_min == 7'd0) && (r_sec == 7'd0);
    assign w_next_zero = (w_next_hour == 7'd0) && (w_next_min == 7'd0) && (w_next_sec == 7'd0);
    assign w_enter_run = (w_next_state == RUN) && (r_state != RUN);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .CLK   (CLK),
        .RESET (RESET),
        .EN    (r_state == RUN),
        .CLR   (w_enter_run),
        .TICK  (w_tick)
    );

    // Time fields and cursor. Countdown and editing never overlap because
    // they are enabled in disjoint states.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        w_next_hour   = r_hour;
        w_next_min    = r_min;
        w_next_sec    = r_sec;
        w_next_cursor = r_cursor;

        if (r_state == RUN && w_tick) begin
            if (r_sec != 7'd0) begin
                w_next_sec = r_sec - 7'd1;
            end else if (r_min != 7'd0) begin
                w_next_sec = SEC_MAX;
                w_next_min = r_min - 7'd1;
            end else if (r_hour != 7'd0) begin
                w_next_sec  = SEC_MAX;
                w_next_min  = MIN_MAX;
                w_next_hour = r_hour - 7'd1;
            end
        end

        // Edit uses the pre-move cursor.
        if (w_edit_en && (w_inc || w_dec)) begin
            case (r_cursor)
                3'd0:    w_next_sec  = edit_field(r_sec,  SEC_MAX,    1'b0, w_inc);
                3'd1:    w_next_sec  = edit_field(r_sec,  SEC_MAX,    1'b1, w_inc);
                3'd2:    w_next_min  = edit_field(r_min,  MIN_MAX,    1'b0, w_inc);
                3'd3:    w_next_min  = edit_field(r_min,  MIN_MAX,    1'b1, w_inc);
                3'd4:    w_next_hour = edit_field(r_hour, HOUR_LIMIT, 1'b0, w_inc);
                3'd5:    w_next_hour = edit_field(r_hour, HOUR_LIMIT, 1'b1, w_inc);
                default: ;
            endcase
        end

        if (w_edit_en && w_right) begin
            w_next_cursor = (r_cursor == CURSOR_LAST) ? 3'd0 : r_cursor + 3'd1;
        end else if (w_edit_en && w_left) begin
            w_next_cursor = (r_cursor == 3'd0) ? CURSOR_LAST : r_cursor - 3'd1;
        end

        if (!w_set_mode) begin
            w_next_cursor = 3'd0;
        end
    end

    // Next-state logic. Expiry wins over a simultaneous pause request.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (START && !w_time_zero) w_next_state = RUN;
            RUN: begin
                if (w_tick && w_next_zero) begin
                    w_next_state = EXPIRED;
                end else if (START) begin
                    w_next_state = PAUSE;
                end
            end
            PAUSE:   if (START) w_next_state = RUN;
            EXPIRED: if (START) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state   <= IDLE;
            r_cursor  <= 3'd0;
            r_hour    <= 7'd0;
            r_min     <= 7'd0;
            r_sec     <= 7'd0;
            r_running <= 1'b0;
            r_alarm   <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_cursor  <= w_next_cursor;
            r_hour    <= w_next_hour;
            r_min     <= w_next_min;
            r_sec     <= w_next_sec;
            r_running <= (w_next_state == RUN);
            r_alarm   <= (w_next_state == EXPIRED);
            r_done    <= (r_state == RUN) && (w_next_state == EXPIRED);
        end
    end

    assign CURSOR  = r_cursor;
    assign HOUR    = r_hour;
    assign MIN     = r_min;
    assign SEC     = r_sec;
    assign RUNNING = r_running;
    assign ALARM   = r_alarm;
    assign DONE    = r_done;

endmodule

// File: tb/tb_timer_countdown_set.sv
// ---------------------------------------------------------------------------
// tb_timer_countdown_set
// Self-checking bench: a seconds-based reference model is compared against
// the DUT on every falling edge, plus hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_timer_countdown_set;

    localparam int         HOUR_MAX_TB = 23;
    localparam int         TICK_DIV_TB = 4;
    localparam logic [3:0] SET_MODE_TB = 4'b0000;

    localparam logic [3:0] K_NONE  = 4'b0000;
    localparam logic [3:0] K_INC   = 4'b0001;
    localparam logic [3:0] K_DEC   = 4'b0010;
    localparam logic [3:0] K_RIGHT = 4'b0100;
    localparam logic [3:0] K_LEFT  = 4'b1000;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_PAUSE = 2;
    localparam int M_EXP  = 3;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [3:0] MODE;
    logic [3:0] NUM_SYNC;
    logic       START;
    logic [2:0] CURSOR;
    logic [6:0] HOUR, MIN, SEC;
    logic       RUNNING, ALARM, DONE;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 0;
    bit got_done;

    timer_countdown_set #(
        .HOUR_MAX (HOUR_MAX_TB),
        .TICK_DIV (TICK_DIV_TB),
        .SET_MODE (SET_MODE_TB)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .MODE     (MODE),
        .NUM_SYNC (NUM_SYNC),
        .START    (START),
        .CURSOR   (CURSOR),
        .HOUR     (HOUR),
        .MIN      (MIN),
        .SEC      (SEC),
        .RUNNING  (RUNNING),
        .ALARM    (ALARM),
        .DONE     (DONE)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // ---------------- reference model: time kept as total seconds ----------
    typedef struct {
        int state;
        int total;
        int cursor;
        int presc;
        bit done;
    } model_t;

    model_t m;

    function automatic int ref_edit(int v, int mx, bit tens, bit up);
        int t = v / 10;
        int o = v % 10;
        if (!tens) begin
            if (up)          o = (o == 9 || v == mx) ? 0 : o + 1;
            else if (o == 0) o = (mx - 10 * t < 9) ? mx - 10 * t : 9;
            else             o = o - 1;
        end else if (up) begin
            t = (10 * (t + 1) + o > mx) ? 0 : t + 1;
        end else if (t > 0) begin
            t = t - 1;
        end else begin
            int best = -1;
            for (int k = 0; k <= 9; k++) if (10 * k + o <= mx) best = k;
            if (best < 0) begin
                o = 0;
                t = mx / 10;
            end else begin
                t = best;
            end
        end
        return 10 * t + o;
    endfunction

    function automatic model_t model_next(model_t c, logic [3:0] mode, logic [3:0] keys, logic st);
        model_t n = c;
        bit set_ok;
        bit tick;
        int h, mi, s;
        n.done = 0;
        set_ok = (mode == SET_MODE_TB) && (c.state == M_IDLE || c.state == M_PAUSE);
        case (c.state)
            M_IDLE: if (st && c.total != 0) n.state = M_RUN;
            M_RUN: begin
                tick    = (c.presc == TICK_DIV_TB - 1);
                n.presc = tick ? 0 : c.presc + 1;
                if (tick && c.total <= 1) begin
                    n.total = 0;
                    n.state = M_EXP;
                    n.done  = 1;
                end else begin
                    if (tick) n.total = c.total - 1;
                    if (st)   n.state = M_PAUSE;
                end
            end
            M_PAUSE: if (st) n.state = M_RUN;
            default: if (st) n.state = M_IDLE;
        endcase
        if (set_ok && (keys[0] ^ keys[1])) begin
            h  = c.total / 3600;
            mi = (c.total / 60) % 60;
            s  = c.total % 60;
            case (c.cursor / 2)
                0:       s  = ref_edit(s,  59,          c.cursor % 2 == 1, keys[0]);
                1:       mi = ref_edit(mi, 59,          c.cursor % 2 == 1, keys[0]);
                default: h  = ref_edit(h,  HOUR_MAX_TB, c.cursor % 2 == 1, keys[0]);
            endcase
            n.total = h * 3600 + mi * 60 + s;
        end
        if (set_ok && (keys[2] ^ keys[3])) n.cursor = keys[2] ? (c.cursor + 1) % 6 : (c.cursor + 5) % 6;
        if (mode != SET_MODE_TB) n.cursor = 0;
        if (n.state == M_RUN && c.state != M_RUN) n.presc = 0;
        return n;
    endfunction

    always @(posedge CLK or negedge RESET) begin
        if (!RESET) m <= '{M_IDLE, 0, 0, 0, 1'b0};
        else        m <= model_next(m, MODE, NUM_SYNC, START);
    end

    // ---------------- per-cycle comparison against the model ---------------
    always @(negedge CLK) begin
        if (cmp_en && RESET) begin
            check("cyc_cursor",  32'(CURSOR),  32'(m.cursor));
            check("cyc_hour",    32'(HOUR),    32'(m.total / 3600));
            check("cyc_min",     32'(MIN),     32'((m.total / 60) % 60));
            check("cyc_sec",     32'(SEC),     32'(m.total % 60));
            check("cyc_running", 32'(RUNNING), 32'(m.state == M_RUN));
            check("cyc_alarm",   32'(ALARM),   32'(m.state == M_EXP));
            check("cyc_done",    32'(DONE),    32'(m.done));
        end
    end

    // Drive one cycle of inputs starting at a falling edge.
    task automatic step(input logic [3:0] keys, input logic st);
        NUM_SYNC = keys;
        START    = st;
        @(negedge CLK);
        NUM_SYNC = K_NONE;
        START    = 1'b0;
    endtask

    task automatic pulse_reset();
        RESET = 1'b0;
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
    endtask

    initial begin
        RESET    = 1'b0;
        MODE     = SET_MODE_TB;
        NUM_SYNC = K_NONE;
        START    = 1'b0;
        repeat (3) @(negedge CLK);
        RESET  = 1'b1;
        cmp_en = 1'b1;
        @(negedge CLK);

        // Reset values.
        check("rst_cursor",  32'(CURSOR),  0);
        check("rst_time",    32'({HOUR, MIN, SEC}), 0);
        check("rst_flags",   32'({RUNNING, ALARM, DONE}), 0);

        // Cursor wrap both directions.
        repeat (7) step(K_RIGHT, 1'b0);
        check("cursor_right7", 32'(CURSOR), 1);
        repeat (2) step(K_LEFT, 1'b0);
        check("cursor_left2", 32'(CURSOR), 5);

        // Hour digit editing with HOUR_MAX=23.
        step(K_INC, 1'b0);   check("hr10_inc_0",  32'(HOUR), 10);
        step(K_LEFT, 1'b0);
        step(K_DEC, 1'b0);   check("hr1_dec_wrap", 32'(HOUR), 19);
        step(K_RIGHT, 1'b0);
        step(K_INC, 1'b0);   check("hr10_inc_wrap", 32'(HOUR), 9);
        step(K_DEC, 1'b0);   check("hr10_dec_wrap", 32'(HOUR), 19);
        step(K_LEFT, 1'b0);
        step(K_INC, 1'b0);   check("hr1_inc_9", 32'(HOUR), 10);
        step(K_RIGHT, 1'b0);
        step(K_INC, 1'b0);
        step(K_LEFT, 1'b0);
        repeat (3) step(K_INC, 1'b0);
        check("hr_23", 32'(HOUR), 23);
        step(K_INC, 1'b0);   check("hr1_inc_at_max", 32'(HOUR), 20);
        step(K_DEC, 1'b0);   check("hr1_dec_from_20", 32'(HOUR), 23);

        // Simultaneous keys.
        step(K_INC | K_DEC, 1'b0);    check("inc_dec_cancel", 32'(HOUR), 23);
        step(K_LEFT | K_RIGHT, 1'b0); check("left_right_cancel", 32'(CURSOR), 4);
        step(K_DEC | K_RIGHT, 1'b0);
        check("edit_premove_hour", 32'(HOUR), 22);
        check("edit_premove_cursor", 32'(CURSOR), 5);

        // Minute / second boundaries.
        repeat (2) step(K_LEFT, 1'b0);
        step(K_DEC, 1'b0);   check("min10_dec_wrap", 32'(MIN), 50);
        step(K_INC, 1'b0);   check("min10_inc_wrap", 32'(MIN), 0);
        repeat (3) step(K_LEFT, 1'b0);
        step(K_DEC, 1'b0);   check("sec1_dec_wrap", 32'(SEC), 9);

        // Leaving SET_MODE forces cursor 0 and blocks editing.
        repeat (2) step(K_RIGHT, 1'b0);
        MODE = 4'b0101;
        step(K_INC, 1'b0);
        check("mode_cursor0", 32'(CURSOR), 0);
        check("mode_no_edit", 32'(MIN), 0);
        MODE = SET_MODE_TB;

        pulse_reset();
        check("rst2_time", 32'({HOUR, MIN, SEC}), 0);

        // Countdown from 00:01:00.
        repeat (2) step(K_RIGHT, 1'b0);
        step(K_INC, 1'b0);
        check("set_min1", 32'(MIN), 1);
        step(K_NONE, 1'b1);
        check("run_running", 32'(RUNNING), 1);
        step(K_INC, 1'b0);
        check("run_no_edit_min", 32'(MIN), 1);
        check("run_no_edit_sec", 32'(SEC), 0);
        repeat (2) @(negedge CLK);
        check("before_first_tick", 32'(SEC), 0);
        @(negedge CLK);
        check("first_tick_sec", 32'(SEC), 59);
        check("first_tick_min", 32'(MIN), 0);

        got_done = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge CLK);
            if (DONE) begin
                got_done = 1;
                break;
            end
        end
        check("done_within_bound", 32'(got_done), 1);
        check("expired_time", 32'({HOUR, MIN, SEC}), 0);
        check("expired_alarm", 32'(ALARM), 1);
        check("expired_not_running", 32'(RUNNING), 0);
        @(negedge CLK);
        check("done_one_cycle", 32'(DONE), 0);
        check("alarm_held", 32'(ALARM), 1);
        step(K_NONE, 1'b1);
        check("ack_alarm_clear", 32'(ALARM), 0);
        step(K_NONE, 1'b1);
        check("start_at_zero", 32'(RUNNING), 0);

        // Pause, edit, resume from 00:00:10.
        step(K_LEFT, 1'b0);
        step(K_INC, 1'b0);
        check("set_sec10", 32'(SEC), 10);
        step(K_NONE, 1'b1);
        repeat (2) @(negedge CLK);
        step(K_NONE, 1'b1);
        check("pause_sec", 32'(SEC), 10);
        check("pause_running", 32'(RUNNING), 0);
        repeat (10) @(negedge CLK);
        check("pause_frozen", 32'(SEC), 10);
        step(K_LEFT, 1'b0);
        step(K_INC, 1'b0);
        check("pause_edit", 32'(SEC), 11);
        step(K_NONE, 1'b1);
        repeat (3) @(negedge CLK);
        check("resume_before_tick", 32'(SEC), 11);
        @(negedge CLK);
        check("resume_tick", 32'(SEC), 10);
        step(K_NONE, 1'b1);
        step(K_INC, 1'b1);
        check("start_edit_sec", 32'(SEC), 11);
        check("start_edit_running", 32'(RUNNING), 1);

        // Asynchronous reset while running.
        @(negedge CLK);
        #3 RESET = 1'b0;
        #1;
        check("async_cursor", 32'(CURSOR), 0);
        check("async_time", 32'({HOUR, MIN, SEC}), 0);
        check("async_running", 32'(RUNNING), 0);
        check("async_alarm", 32'(ALARM), 0);
        check("async_done", 32'(DONE), 0);
        repeat (3) begin
            @(negedge CLK);
            check("reset_no_done", 32'(DONE), 0);
        end
        RESET = 1'b1;
        repeat (5) @(negedge CLK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
